load_store_unit: RTL

// - Memory stage directly downstream of the ALU: consumes the ALU result as the effective

---
 rtl/load_store_unit_pkg.sv | 16 +
 rtl/bus_timeout_counter.sv | 36 +++
 rtl/load_store_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: FSM encoding and word-alignment test.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent waiting on the data-memory bus; expired flags the last allowed cycle.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: turns an ALU effective address into a req/ack data-bus access,
// stalls the core while it is in flight and returns load data with a done/err pulse.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic              op_load,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ld_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              in_req;
    logic              expired;

    assign in_req = (state_q == LSU_REQ);

    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ld_data_d   = ld_data_q;
        stall       = 1'b0;

        case (state_q)
            LSU_IDLE: begin
                if (op_valid) begin
                    stall = 1'b1;
                    if (is_word_aligned(alu_addr[1:0])) begin
                        state_d     = LSU_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~op_load;
                        mem_addr_d  = alu_addr;
                        mem_wdata_d = st_data;
                    end else begin
                        state_d   = LSU_DONE;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        ld_data_d = '0;
                    end
                end
            end
            LSU_REQ: begin
                stall = 1'b1;
                // An ack on the expiry cycle still completes the access cleanly.
                if (mem_ack) begin
                    state_d   = LSU_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    ld_data_d = mem_we_q ? '0 : mem_rdata;
                end else if (expired) begin
                    state_d   = LSU_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    ld_data_d = '0;
                end
            end
            LSU_DONE: begin
                state_d = LSU_IDLE;
            end
            default: begin
                state_d   = LSU_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LSU_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ld_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ld_data_q   <= ld_data_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign ld_data   = ld_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
